op_input_ctrl: RTL and testbench



---
 rtl/op_input_ctrl.sv | 108 ++++++++++
 tb/tb_op_input_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/op_input_ctrl.sv
// Button front end: synchronize, debounce, detect presses, auto-repeat direction keys,
// and issue at most one one-hot operation pulse per clock (confirm has highest priority).
module op_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn,
  output logic [4:0] operation,
  output logic [4:0] btn_level
);

  localparam int unsigned NB   = 5;
  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] stable_q, stable_d;
  logic [NB-1:0] stable_dly_q, stable_dly_d;
  logic [NB-1:0] pend_q, pend_d;
  logic [NB-1:0] op_q, op_d;
  logic [DW-1:0] db_cnt_q [NB];
  logic [DW-1:0] db_cnt_d [NB];
  logic [HW-1:0] hold_cnt_q [1:NB-1];
  logic [HW-1:0] hold_cnt_d [1:NB-1];
  logic [HW-1:0] hold_lim_c [1:NB-1];
  logic [NB-1:1] period_q, period_d;

  logic [NB-1:0] press_c;
  logic [NB-1:0] rep_c;
  logic [NB-1:0] issue_c;

  // Next-state: synchronizer, debounce, hold/repeat counters, pending set and issue.
  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    press_c      = stable_q & ~stable_dly_q;
    rep_c        = '0;

    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end

    // Confirm (bit 0) never repeats; only direction keys have hold counters.
    for (int i = 1; i < NB; i++) begin
      hold_lim_c[i] = period_q[i] ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1);
      hold_cnt_d[i] = hold_cnt_q[i];
      period_d[i]   = period_q[i];
      if (!stable_q[i] || press_c[i]) begin
        hold_cnt_d[i] = '0;
        period_d[i]   = 1'b0;
      end else if (hold_cnt_q[i] == hold_lim_c[i]) begin
        rep_c[i]      = 1'b1;
        hold_cnt_d[i] = '0;
        period_d[i]   = 1'b1;
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
      end
    end

    // Lowest set bit wins; a same-cycle event on the issued bit re-arms it.
    issue_c = pend_q & (~pend_q + NB'(1));
    op_d    = issue_c;
    pend_d  = (pend_q & ~issue_c) | press_c | rep_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pend_q       <= '0;
      op_q         <= '0;
      period_q     <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      for (int i = 1; i < NB; i++) hold_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pend_q       <= pend_d;
      op_q         <= op_d;
      period_q     <= period_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 1; i < NB; i++) hold_cnt_q[i] <= hold_cnt_d[i];
    end
  end

  assign operation = op_q;
  assign btn_level = stable_q;

endmodule

// File: tb/tb_op_input_ctrl.sv
// Testbench for op_input_ctrl: directed vector table, hand-written order/reset sequences,
// and random button activity checked every cycle against a behavioural model.
module tb_op_input_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int IDLE = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  logic [4:0] operation;
  logic [4:0] btn_level;

  op_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .operation(operation),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: run length of disagreement, age since press, pending set.
  logic [4:0] m_s1, m_s2, m_stable, m_prev, m_pend, m_op;
  int m_run [5];
  int m_age [5];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pend = '0; m_op = '0;
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0;
      m_age[i] = -1;
    end
  endtask

  task automatic model_step(input logic [4:0] b);
    logic [4:0] press, rep, ev, issue, st_new;
    logic found;
    press = m_stable & ~m_prev;
    rep = '0;
    for (int i = 1; i < 5; i++)
      if (m_stable[i] && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0) rep[i] = 1'b1;
    ev = press | rep;
    issue = '0;
    found = 1'b0;
    for (int i = 0; i < 5; i++)
      if (!found && m_pend[i]) begin
        issue[i] = 1'b1;
        found = 1'b1;
      end
    st_new = m_stable;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] == m_stable[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          st_new[i] = m_s2[i];
          m_run[i] = 0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (!st_new[i]) m_age[i] = -1;
      else if (!m_stable[i]) m_age[i] = 0;
      else m_age[i]++;
    end
    m_op     = issue;
    m_pend   = (m_pend & ~issue) | ev;
    m_prev   = m_stable;
    m_stable = st_new;
    m_s2     = m_s1;
    m_s1     = b;
  endtask

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(btn);
    else model_reset();
    @(negedge clk);
    check5("operation", operation, m_op);
    check5("btn_level", btn_level, m_stable);
    check_int("onehot", int'($countones(operation)) <= 1 ? 1 : 0, 1);
  endtask

  typedef struct {
    logic [4:0] btn;
    int         hold;
    int         first;
    int         pulses;
    logic [4:0] seen;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int idx);
    int pulses;
    int first;
    logic [4:0] seen;
    pulses = 0;
    first  = -1;
    seen   = '0;
    btn    = v.btn;
    for (int k = 0; k < v.hold + IDLE; k++) begin
      if (k == v.hold) btn = '0;
      tick();
      if (operation != '0) begin
        pulses++;
        seen |= operation;
        if (first < 0) first = k;
      end
    end
    check_int($sformatf("vec%0d_pulses", idx), pulses, v.pulses);
    check_int($sformatf("vec%0d_first", idx), first, v.first);
    check5($sformatf("vec%0d_bits", idx), seen, v.seen);
  endtask

  initial begin
    vecs[0] = '{btn: 5'b00010, hold: 8,  first: 7,  pulses: 1, seen: 5'b00010};
    vecs[1] = '{btn: 5'b00001, hold: 3,  first: -1, pulses: 0, seen: 5'b00000};
    vecs[2] = '{btn: 5'b10000, hold: 40, first: 7,  pulses: 7, seen: 5'b10000};
    vecs[3] = '{btn: 5'b00001, hold: 40, first: 7,  pulses: 1, seen: 5'b00001};
    vecs[4] = '{btn: 5'b11111, hold: 8,  first: 7,  pulses: 5, seen: 5'b11111};
    vecs[5] = '{btn: 5'b01000, hold: 15, first: 7,  pulses: 2, seen: 5'b01000};
    vecs[6] = '{btn: 5'b00010, hold: 4,  first: 7,  pulses: 1, seen: 5'b00010};
    vecs[7] = '{btn: 5'b01100, hold: 14, first: 7,  pulses: 4, seen: 5'b01100};

    rst_n = 1'b0;
    btn   = '0;
    model_reset();
    #2;
    check5("reset_op", operation, 5'b00000);
    check5("reset_lvl", btn_level, 5'b00000);
    repeat (2) tick();
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // All buttons together: priority order on consecutive cycles.
    btn = 5'b11111;
    for (int k = 0; k < 8 + IDLE; k++) begin
      logic [4:0] exp;
      if (k == 8) btn = '0;
      tick();
      exp = (k >= 7 && k <= 11) ? (5'b00001 << (k - 7)) : 5'b00000;
      check5($sformatf("order_k%0d", k), operation, exp);
    end

    // Reset while btn[2] is pending: everything clears at once, then a fresh press.
    btn = 5'b00100;
    for (int k = 0; k < 7; k++) tick();
    check5("pre_reset_lvl", btn_level, 5'b00100);
    rst_n = 1'b0;
    model_reset();
    #1;
    check5("async_op", operation, 5'b00000);
    check5("async_lvl", btn_level, 5'b00000);
    repeat (3) tick();
    rst_n = 1'b1;
    begin
      int pulses;
      int first;
      pulses = 0;
      first  = -1;
      for (int k = 0; k < 9; k++) begin
        tick();
        if (operation != '0) begin
          pulses++;
          if (first < 0) first = k;
        end
      end
      btn = '0;
      for (int k = 9; k < 9 + IDLE; k++) begin
        tick();
        if (operation != '0) pulses++;
      end
      check_int("post_reset_first", first, DEB + 3);
      check_int("post_reset_pulses", pulses, 1);
    end

    // Random button activity against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) btn[$urandom_range(4)] ^= 1'b1;
      tick();
    end
    btn = '0;
    repeat (IDLE) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
